neuron_sweep_ctrl: RTL and testbench

Event-driven sequencer sitting directly upstream of the IF neuron datapath. It accepts synaptic, time-step and time-reference events, sweeps all post-synaptic neurons through the neuron state SRAM and weight SRAM, and drives the neuron's inputs and event strobes. It writes the neuron's next state back and queues fired spikes as post-neuron addresses for the downstream spike consumer.

---
 rtl/neuron_sweep_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_neuron_sweep_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_sweep_ctrl.sv
// Event-driven sweep sequencer for the IF neuron datapath: walks every post-neuron
// through state/weight SRAM and queues fired spikes. Define EVT_FIFO_EN for a 4-deep input event FIFO.
// state  | meaning
// IDLE   | no sweep active, waiting for an event
// SWEEP  | read/write pipeline walking neurons 0..N_NEURONS-1
module neuron_sweep_ctrl #(
  parameter int N_NEURONS = 256,
  parameter int ADDR_W    = $clog2(N_NEURONS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  evt_valid,
  output logic                  evt_ready,
  input  logic [1:0]            evt_type,
  input  logic [ADDR_W-1:0]     evt_addr,
  output logic [ADDR_W-1:0]     st_raddr,
  output logic                  st_rd_en,
  input  logic [18:0]           st_rdata,
  output logic [ADDR_W-1:0]     st_waddr,
  output logic                  st_wr_en,
  output logic [18:0]           st_wdata,
  output logic [2*ADDR_W-1:0]   w_addr,
  output logic                  w_rd_en,
  input  logic [7:0]            w_rdata,
  output logic [11:0]           nrn_state_core,
  output logic [6:0]            nrn_post_spike_cnt,
  output logic [7:0]            nrn_syn_weight,
  output logic                  nrn_neuron_event,
  output logic                  nrn_time_step_event,
  output logic                  nrn_time_ref_event,
  input  logic [11:0]           nrn_state_core_next,
  input  logic [6:0]            nrn_post_spike_cnt_next,
  input  logic                  nrn_spike_out,
  output logic                  spk_valid,
  input  logic                  spk_ready,
  output logic [ADDR_W-1:0]     spk_addr,
  output logic                  busy
);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;
  typedef enum logic [1:0] {M_SYN = 2'b00, M_STEP = 2'b01, M_REF = 2'b10} mode_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_NEURONS - 1);

  state_t              state_q, state_d;
  mode_t               mode_q, mode_d, wr_mode_q, wr_mode_d;
  logic [ADDR_W-1:0]   pre_q, pre_d, rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic                rd_act_q, rd_act_d, wr_vld_q, wr_vld_d;
  logic [ADDR_W-1:0]   spk_mem_q [2];
  logic                spk_wp_q, spk_rp_q;
  logic [1:0]          spk_cnt_q;

  logic                nxt_valid, start_ok, take, start;
  logic [1:0]          nxt_type;
  logic [ADDR_W-1:0]   nxt_addr;
  logic                rd_ok, rd_issue, wr_last, spk_push, spk_pop;

  // STEP may fire every neuron; hold reads so the 2-entry spike queue cannot overflow
  assign rd_ok    = (mode_q != M_STEP) || (spk_cnt_q == 2'd0) ||
                    ((spk_cnt_q == 2'd1) && spk_ready);
  assign rd_issue = rd_act_q && rd_ok;
  assign wr_last  = wr_vld_q && (wr_idx_q == LAST);

`ifdef EVT_FIFO_EN
  logic [1:0]        ef_type_q [4];
  logic [ADDR_W-1:0] ef_addr_q [4];
  logic [1:0]        ef_wp_q, ef_rp_q;
  logic [2:0]        ef_cnt_q;
  logic              ef_push, ef_pop, ef_empty;

  assign ef_empty  = (ef_cnt_q == 3'd0);
  assign evt_ready = (ef_cnt_q != 3'd4);
  // an empty queue lets the incoming event start directly, keeping single-event latency unchanged
  assign nxt_valid = !ef_empty || evt_valid;
  assign nxt_type  = ef_empty ? evt_type : ef_type_q[ef_rp_q];
  assign nxt_addr  = ef_empty ? evt_addr : ef_addr_q[ef_rp_q];
  assign start_ok  = !rd_act_q || (rd_issue && (rd_idx_q == LAST));
  assign ef_pop    = take && !ef_empty;
  assign ef_push   = evt_valid && evt_ready && !(take && ef_empty);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ef_wp_q  <= '0;
      ef_rp_q  <= '0;
      ef_cnt_q <= '0;
      for (int i = 0; i < 4; i++) begin
        ef_type_q[i] <= '0;
        ef_addr_q[i] <= '0;
      end
    end else begin
      if (ef_push) begin
        ef_type_q[ef_wp_q] <= evt_type;
        ef_addr_q[ef_wp_q] <= evt_addr;
        ef_wp_q            <= ef_wp_q + 2'd1;
      end
      if (ef_pop) ef_rp_q <= ef_rp_q + 2'd1;
      ef_cnt_q <= ef_cnt_q + {2'b0, ef_push} - {2'b0, ef_pop};
    end
  end
`else
  assign evt_ready = (state_q == S_IDLE);
  assign nxt_valid = evt_valid;
  assign nxt_type  = evt_type;
  assign nxt_addr  = evt_addr;
  assign start_ok  = (state_q == S_IDLE);
`endif

  assign take  = nxt_valid && start_ok;
  assign start = take && (nxt_type != 2'b11);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      mode_q    <= M_SYN;
      wr_mode_q <= M_SYN;
      pre_q     <= '0;
      rd_idx_q  <= '0;
      wr_idx_q  <= '0;
      rd_act_q  <= 1'b0;
      wr_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      wr_mode_q <= wr_mode_d;
      pre_q     <= pre_d;
      rd_idx_q  <= rd_idx_d;
      wr_idx_q  <= wr_idx_d;
      rd_act_q  <= rd_act_d;
      wr_vld_q  <= wr_vld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pre_d     = pre_q;
    rd_idx_d  = rd_idx_q;
    rd_act_d  = rd_act_q;
    wr_vld_d  = rd_issue;
    wr_idx_d  = wr_idx_q;
    wr_mode_d = wr_mode_q;
    if (rd_issue) begin
      wr_idx_d  = rd_idx_q;
      wr_mode_d = mode_q;
      if (rd_idx_q == LAST) rd_act_d = 1'b0;
      else                  rd_idx_d = rd_idx_q + 1'b1;
    end
    if (start) begin
      state_d  = S_SWEEP;
      mode_d   = mode_t'(nxt_type);
      pre_d    = nxt_addr;
      rd_idx_d = '0;
      rd_act_d = 1'b1;
    end else if ((state_q == S_SWEEP) && wr_last && !rd_act_q) begin
      state_d = S_IDLE;
    end
  end

  assign spk_valid = (spk_cnt_q != 2'd0);
  assign spk_addr  = spk_mem_q[spk_rp_q];
  assign spk_pop   = spk_valid && spk_ready;
  assign spk_push  = wr_vld_q && nrn_spike_out && ((spk_cnt_q != 2'd2) || spk_pop);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      spk_mem_q[0] <= '0;
      spk_mem_q[1] <= '0;
      spk_wp_q     <= 1'b0;
      spk_rp_q     <= 1'b0;
      spk_cnt_q    <= '0;
    end else begin
      if (spk_push) begin
        spk_mem_q[spk_wp_q] <= wr_idx_q;
        spk_wp_q            <= ~spk_wp_q;
      end
      if (spk_pop) spk_rp_q <= ~spk_rp_q;
      spk_cnt_q <= spk_cnt_q + {1'b0, spk_push} - {1'b0, spk_pop};
    end
  end

  assign st_rd_en            = rd_issue;
  assign st_raddr            = rd_idx_q;
  assign w_rd_en             = rd_issue && (mode_q == M_SYN);
  assign w_addr              = w_rd_en ? {pre_q, rd_idx_q} : '0;
  assign st_wr_en            = wr_vld_q;
  assign st_waddr            = wr_idx_q;
  assign st_wdata            = wr_vld_q ? {nrn_post_spike_cnt_next, nrn_state_core_next} : '0;
  assign nrn_state_core      = st_rdata[11:0];
  assign nrn_post_spike_cnt  = st_rdata[18:12];
  assign nrn_syn_weight      = (wr_vld_q && (wr_mode_q == M_SYN)) ? w_rdata : '0;
  assign nrn_neuron_event    = wr_vld_q && (wr_mode_q == M_SYN);
  assign nrn_time_step_event = wr_vld_q && (wr_mode_q == M_STEP);
  assign nrn_time_ref_event  = wr_vld_q && (wr_mode_q == M_REF);
  assign busy                = (state_q == S_SWEEP);

endmodule

// File: tb/tb_neuron_sweep_ctrl.sv
// Directed bench for neuron_sweep_ctrl with N=4, behavioural SRAMs and a simple IF neuron (threshold 50).
module tb_neuron_sweep_ctrl;
  localparam int N  = 4;
  localparam int AW = 2;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic evt_valid, evt_ready, st_rd_en, st_wr_en, w_rd_en, spk_valid, spk_ready, busy;
  logic nrn_neuron_event, nrn_time_step_event, nrn_time_ref_event, nrn_spike_out;
  logic [1:0] evt_type;
  logic [AW-1:0] evt_addr, st_raddr, st_waddr, spk_addr;
  logic [18:0] st_rdata, st_wdata;
  logic [2*AW-1:0] w_addr;
  logic [7:0] w_rdata, nrn_syn_weight;
  logic [11:0] nrn_state_core, nrn_state_core_next;
  logic [6:0] nrn_post_spike_cnt, nrn_post_spike_cnt_next;

  neuron_sweep_ctrl #(.N_NEURONS(N), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
    .evt_addr(evt_addr), .st_raddr(st_raddr), .st_rd_en(st_rd_en), .st_rdata(st_rdata),
    .st_waddr(st_waddr), .st_wr_en(st_wr_en), .st_wdata(st_wdata), .w_addr(w_addr),
    .w_rd_en(w_rd_en), .w_rdata(w_rdata), .nrn_state_core(nrn_state_core),
    .nrn_post_spike_cnt(nrn_post_spike_cnt), .nrn_syn_weight(nrn_syn_weight),
    .nrn_neuron_event(nrn_neuron_event), .nrn_time_step_event(nrn_time_step_event),
    .nrn_time_ref_event(nrn_time_ref_event), .nrn_state_core_next(nrn_state_core_next),
    .nrn_post_spike_cnt_next(nrn_post_spike_cnt_next), .nrn_spike_out(nrn_spike_out),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_addr(spk_addr), .busy(busy));

  // weight SRAM contents: pre=2 row holds the test weights, pre=3 row a marker
  function automatic logic [7:0] wt(input logic [3:0] a);
    case (a)
      4'd8:    wt = 8'd5;
      4'd9:    wt = 8'hFD;
      4'd10:   wt = 8'd0;
      4'd11:   wt = 8'h7F;
      4'd12:   wt = 8'h11;
      default: wt = 8'h00;
    endcase
  endfunction

  logic [18:0] st_mem [N];
  logic ld_en;
  logic [AW-1:0] ld_a;
  logic [18:0] ld_d;
  always @(posedge CLK) begin
    if (st_rd_en) st_rdata <= st_mem[st_raddr];
    if (w_rd_en)  w_rdata  <= wt(w_addr);
    if (st_wr_en) st_mem[st_waddr] <= st_wdata;
    if (ld_en)    st_mem[ld_a] <= ld_d;
  end

  always_comb begin
    nrn_state_core_next     = nrn_state_core;
    nrn_post_spike_cnt_next = nrn_post_spike_cnt;
    nrn_spike_out           = 1'b0;
    if (nrn_neuron_event) begin
      nrn_state_core_next = nrn_state_core + {{4{nrn_syn_weight[7]}}, nrn_syn_weight};
    end else if (nrn_time_step_event) begin
      if ($signed(nrn_state_core) >= 12'sd50) begin
        nrn_state_core_next     = 12'd0;
        nrn_post_spike_cnt_next = nrn_post_spike_cnt + 7'd1;
        nrn_spike_out           = 1'b1;
      end
    end else if (nrn_time_ref_event) begin
      nrn_state_core_next     = 12'd0;
      nrn_post_spike_cnt_next = 7'd0;
    end
  end

  int wr_cnt = 0;
  int occ = 0;
  int spk_q [$];
  always @(posedge CLK) begin
    if (RST) occ = 0;
    else begin
      if (st_wr_en) wr_cnt = wr_cnt + 1;
      if (st_wr_en && nrn_spike_out) occ = occ + 1;
      if (spk_valid && spk_ready) begin
        spk_q.push_back(int'(spk_addr));
        occ = occ - 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load4(input logic [18:0] a, input logic [18:0] b, input logic [18:0] c, input logic [18:0] d);
    logic [18:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      ld_en = 1'b1; ld_a = AW'(i); ld_d = v[i];
    end
    @(negedge CLK);
    ld_en = 1'b0;
  endtask

  task automatic send(input logic [1:0] ty, input logic [AW-1:0] ad);
    @(negedge CLK);
    evt_valid = 1'b1; evt_type = ty; evt_addr = ad;
    chk("evt_ready_before_accept", {31'd0, evt_ready}, 32'd1);
    @(posedge CLK);
    #1 evt_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] syn_exp [4];
    int mx, first, last, nw, k;
    bit done;
    syn_exp[0] = 19'd5; syn_exp[1] = 19'h00FFD; syn_exp[2] = 19'd0; syn_exp[3] = 19'h0007F;
    RST = 1'b1; evt_valid = 1'b0; evt_type = 2'b00; evt_addr = '0; spk_ready = 1'b0;
    ld_en = 1'b0; ld_a = '0; ld_d = '0;
    repeat (2) @(negedge CLK);
    chk("rst_evt_ready", {31'd0, evt_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_en", {31'd0, st_rd_en}, 32'd0);
    chk("rst_wr_en", {31'd0, st_wr_en}, 32'd0);
    chk("rst_w_rd_en", {31'd0, w_rd_en}, 32'd0);
    chk("rst_spk_valid", {31'd0, spk_valid}, 32'd0);
    chk("rst_strobes", {29'd0, nrn_neuron_event, nrn_time_step_event, nrn_time_ref_event}, 32'd0);
    chk("rst_st_wdata", {13'd0, st_wdata}, 32'd0);
    chk("rst_w_addr", {28'd0, w_addr}, 32'd0);
    chk("rst_addrs", {26'd0, st_raddr, st_waddr, spk_addr}, 32'd0);
    RST = 1'b0;
    load4(19'd0, 19'd0, 19'd0, 19'd0);

    // synaptic sweep from pre-neuron 2
    send(2'b00, 2'd2);
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      if (c <= 4) begin
        chk("syn_rd_en", {31'd0, st_rd_en}, 32'd1);
        chk("syn_raddr", {30'd0, st_raddr}, 32'(c - 1));
        chk("syn_w_addr", {28'd0, w_addr}, 32'(8 + c - 1));
        chk("syn_busy", {31'd0, busy}, 32'd1);
      end else chk("syn_rd_done", {31'd0, st_rd_en}, 32'd0);
      if (c >= 2 && c <= 5) begin
        chk("syn_wr_en", {31'd0, st_wr_en}, 32'd1);
        chk("syn_waddr", {30'd0, st_waddr}, 32'(c - 2));
        chk("syn_wdata", {13'd0, st_wdata}, {13'd0, syn_exp[c-2]});
        chk("syn_strobe", {29'd0, nrn_neuron_event, nrn_time_step_event, nrn_time_ref_event}, 32'd4);
      end else chk("syn_no_wr", {31'd0, st_wr_en}, 32'd0);
`ifndef EVT_FIFO_EN
      if (c == 1) chk("syn_ready_low", {31'd0, evt_ready}, 32'd0);
`endif
      if (c == 6) begin
        chk("syn_idle_busy", {31'd0, busy}, 32'd0);
        chk("syn_idle_ready", {31'd0, evt_ready}, 32'd1);
      end
    end

    // time step with partial firing
    load4(19'd100, 19'd10, 19'd100, 19'd100);
    spk_ready = 1'b1;
    spk_q.delete();
    send(2'b01, 2'd0);
    repeat (7) @(negedge CLK);
    chk("step_busy_done", {31'd0, busy}, 32'd0);
    chk("step_spk_count", 32'(spk_q.size()), 32'd3);
    if (spk_q.size() == 3) begin
      chk("step_spk0", 32'(spk_q[0]), 32'd0);
      chk("step_spk1", 32'(spk_q[1]), 32'd2);
      chk("step_spk2", 32'(spk_q[2]), 32'd3);
    end
    chk("step_mem0", {13'd0, st_mem[0]}, 32'h1000);
    chk("step_mem1", {13'd0, st_mem[1]}, 32'd10);
    chk("step_mem2", {13'd0, st_mem[2]}, 32'h1000);
    chk("step_mem3", {13'd0, st_mem[3]}, 32'h1000);

    // time step, all firing, consumer stalled
    load4(19'd100, 19'd100, 19'd100, 19'd100);
    spk_ready = 1'b0;
    spk_q.delete();
    nw = wr_cnt;
    mx = 0;
    send(2'b01, 2'd0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (occ > mx) mx = occ;
    end
    chk("stall_writes", 32'(wr_cnt - nw), 32'd2);
    chk("stall_no_read", {31'd0, st_rd_en}, 32'd0);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    spk_ready = 1'b1;
    done = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      @(negedge CLK);
      if (occ > mx) mx = occ;
      done = !busy && !spk_valid;
      k++;
    end
    chk("stall_drain_timeout", {31'd0, done}, 32'd1);
    chk("stall_max_occ", {31'd0, mx <= 2}, 32'd1);
    chk("stall_total_writes", 32'(wr_cnt - nw), 32'd4);
    chk("stall_spk_count", 32'(spk_q.size()), 32'd4);
    if (spk_q.size() == 4)
      for (int i = 0; i < 4; i++) chk("stall_spk_order", 32'(spk_q[i]), 32'(i));

    // time reference clears everything
    send(2'b10, 2'd0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      if (c == 1) chk("ref_no_wread", {31'd0, w_rd_en}, 32'd0);
      if (c >= 2) begin
        chk("ref_wr_en", {31'd0, st_wr_en}, 32'd1);
        chk("ref_wdata", {13'd0, st_wdata}, 32'd0);
        chk("ref_strobe", {29'd0, nrn_neuron_event, nrn_time_step_event, nrn_time_ref_event}, 32'd1);
        chk("ref_weight", {24'd0, nrn_syn_weight}, 32'd0);
      end
    end
    repeat (2) @(negedge CLK);

    // reserved type is dropped
    send(2'b11, 2'd1);
    @(negedge CLK);
    chk("rsv_busy", {31'd0, busy}, 32'd0);
    chk("rsv_rd_en", {31'd0, st_rd_en}, 32'd0);

    // reset in the middle of a synaptic sweep
    send(2'b00, 2'd1);
    repeat (3) @(negedge CLK);
    chk("rstm_raddr", {30'd0, st_raddr}, 32'd2);
    RST = 1'b1;
    #1;
    chk("rstm_wr_en", {31'd0, st_wr_en}, 32'd0);
    chk("rstm_rd_en", {31'd0, st_rd_en}, 32'd0);
    chk("rstm_busy", {31'd0, busy}, 32'd0);
    chk("rstm_ready", {31'd0, evt_ready}, 32'd1);
    chk("rstm_strobe", {29'd0, nrn_neuron_event, nrn_time_step_event, nrn_time_ref_event}, 32'd0);
    nw = wr_cnt;
    repeat (3) @(negedge CLK);
    chk("rstm_no_writes", 32'(wr_cnt - nw), 32'd0);
    RST = 1'b0;
    send(2'b00, 2'd3);
    @(negedge CLK);
    chk("rstm_restart_raddr", {30'd0, st_raddr}, 32'd0);
    chk("rstm_restart_waddr", {28'd0, w_addr}, 32'd12);
    chk("rstm_restart_rd_en", {31'd0, st_rd_en}, 32'd1);
    repeat (6) @(negedge CLK);

`ifdef EVT_FIFO_EN
    // three back-to-back events form contiguous sweeps
    @(negedge CLK);
    evt_valid = 1'b1; evt_type = 2'b00; evt_addr = 2'd1;
    chk("fifo_ready0", {31'd0, evt_ready}, 32'd1);
    first = -1; last = -1; nw = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (c <= 2) chk("fifo_ready", {31'd0, evt_ready}, 32'd1);
      if (c == 3) evt_valid = 1'b0;
      if (st_rd_en && first < 0) first = c;
      if (st_wr_en) begin last = c; nw++; end
    end
    chk("fifo_first_read", 32'(first), 32'd1);
    chk("fifo_span", 32'(last - first + 1), 32'(3 * N + 1));
    chk("fifo_writes", 32'(nw), 32'(3 * N));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
